tm1638_regbank: RTL



---
 rtl/tm1638_regbank.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/tm1638_regbank.sv
// TM1638 second-generation bus register bank: digit/LED/control registers, button
// debounce, press/release event FIFO and interrupt. Define TM1638_DEBOUNCE_EN to build the debounce counters.
module tm1638_regbank #(
  parameter logic [11:0] CFG_ADDR       = 12'hFF0,
  parameter int          NUM_DIGITS     = 8,
  parameter int          FIFO_DEPTH     = 4,
  parameter int          DEBOUNCE_SCANS = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [15:0]             addr,
  input  logic [7:0]              din,
  input  logic                    wr,
  input  logic                    rd,
  output logic [7:0]              dout,
  output logic                    cs,
  output logic                    irq,
  output logic [8*NUM_DIGITS-1:0] digits,
  output logic [7:0]              leds,
  output logic                    disp_on,
  output logic [2:0]              bright,
  input  logic [7:0]              buttons_in,
  input  logic                    buttons_valid
);

  localparam int            PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int            CW       = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  localparam logic [3:0] OFF_LEDS   = 4'h8;
  localparam logic [3:0] OFF_STABLE = 4'h9;
  localparam logic [3:0] OFF_EVENT  = 4'hA;
  localparam logic [3:0] OFF_STATUS = 4'hB;
  localparam logic [3:0] OFF_IRQEN  = 4'hC;
  localparam logic [3:0] OFF_CTRL   = 4'hF;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15)
  begin : g_bad_param
    $error("tm1638_regbank: parameter out of range");
  end

  logic [7:0]    r_digits [NUM_DIGITS];
  logic [7:0]    r_leds;
  logic          r_disp_on;
  logic [2:0]    r_bright;
  logic [1:0]    r_irq_en;
  logic          r_ovf;
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_count;
  logic [7:0]    r_stable, r_pend, r_pol;
  logic          r_ev_rd_q;
  logic [7:0]    r_dout;
  logic          r_cs, r_irq;

  logic       w_hit, w_wr, w_rd, w_ev_rd, w_pop, w_push, w_push_ok, w_ovf_set;
  logic       w_empty, w_full;
  logic [3:0] w_off;
  logic [2:0] w_idx;
  logic [7:0] w_flip, w_new_stable, w_event, w_head, w_status, w_rdata;

  assign w_hit   = (addr[15:4] == CFG_ADDR);
  assign w_off   = addr[3:0];
  assign w_wr    = w_hit & wr;
  assign w_rd    = w_hit & rd;
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

  // Pop only on the first cycle of an event-register read so a held strobe pops once.
  assign w_ev_rd   = w_rd & (w_off == OFF_EVENT);
  assign w_pop     = w_ev_rd & ~r_ev_rd_q & ~w_empty;
  assign w_push    = |r_pend;
  assign w_push_ok = w_push & (~w_full | w_pop);
  assign w_ovf_set = w_push & ~w_push_ok;

`ifdef TM1638_DEBOUNCE_EN
  localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_SCANS);
  logic [3:0] r_cnt [8];
  logic [3:0] w_cnt_nxt [8];

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < 8; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (buttons_valid) begin
        if (buttons_in[i] != r_stable[i]) begin
          if (r_cnt[i] + 4'd1 == DB_LIMIT) begin
            w_flip[i]    = 1'b1;
            w_cnt_nxt[i] = '0;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + 4'd1;
          end
        end else begin
          w_cnt_nxt[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
`else
  assign w_flip = buttons_valid ? (buttons_in ^ r_stable) : 8'h00;
`endif

  assign w_new_stable = r_stable ^ w_flip;

  always_comb begin
    w_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (r_pend[i]) w_idx = 3'(i);
    end
  end

  assign w_event  = {~r_pol[w_idx], 4'b0000, w_idx};
  assign w_head   = w_empty ? 8'h00 : r_fifo[r_rp];
  assign w_status = {r_ovf, w_empty, w_full, 5'(r_count)};

  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_LEDS:   w_rdata = r_leds;
      OFF_STABLE: w_rdata = r_stable;
      OFF_EVENT:  w_rdata = w_head;
      OFF_STATUS: w_rdata = w_status;
      OFF_IRQEN:  w_rdata = {6'b0, r_irq_en};
      OFF_CTRL:   w_rdata = {4'b0, r_disp_on, r_bright};
      default: begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (w_off == 4'(i)) w_rdata = r_digits[i];
        end
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_digits[i] <= '0;
      r_leds    <= '0;
      r_disp_on <= 1'b1;
      r_bright  <= 3'd7;
      r_irq_en  <= '0;
      r_ovf     <= 1'b0;
      r_wp      <= '0;
      r_rp      <= '0;
      r_count   <= '0;
      r_stable  <= '0;
      r_pend    <= '0;
      r_pol     <= '0;
      r_ev_rd_q <= 1'b0;
      r_dout    <= '0;
      r_cs      <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_wr && w_off == 4'(i)) r_digits[i] <= din;
      end
      if (w_wr) begin
        case (w_off)
          OFF_LEDS:  r_leds   <= din;
          OFF_IRQEN: r_irq_en <= din[1:0];
          OFF_CTRL: begin
            r_disp_on <= din[3];
            r_bright  <= din[2:0];
          end
          default: ;
        endcase
      end
      if (w_ovf_set) r_ovf <= 1'b1;
      else if (w_wr && w_off == OFF_STATUS && din[7]) r_ovf <= 1'b0;

      if (w_push_ok) r_wp <= r_wp + PW'(1);
      if (w_pop)     r_rp <= r_rp + PW'(1);
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop);

      r_stable  <= w_new_stable;
      r_pend    <= (r_pend & ~(8'h01 << w_idx)) | w_flip;
      r_pol     <= (r_pol & ~w_flip) | (w_new_stable & w_flip);
      r_ev_rd_q <= w_ev_rd;

      r_cs <= w_rd;
      if (w_rd) r_dout <= w_rdata;
      r_irq <= (r_irq_en[0] & ~w_empty) | (r_irq_en[1] & r_ovf);
    end
  end

  // NOTE: FIFO storage is left unreset; the pointers and count alone define its contents.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo[r_wp] <= w_event;
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    assign digits[8*g +: 8] = r_digits[g];
  end

  assign dout    = r_dout;
  assign cs      = r_cs;
  assign irq     = r_irq;
  assign leds    = r_leds;
  assign disp_on = r_disp_on;
  assign bright  = r_bright;

endmodule
